rf_port_arbiter: RTL
====================

# rf_port_arbiter

Two-requester round-robin arbiter and sequencer for the 16x32 register file. It accepts read, write or read+write operations from requesters A and B over a req/gnt handshake and drives the register file control ports (`EN`, `RD`, `WR`, selects, write data). It returns read data with a one-cycle response strobe tagged to the issuing requester. It sits between the decode/execute stages and the register file, so no requester drives the file directly.

## Interface
- `DW`, 32, data width; matches the register file word.
- `AW`, 4, register select width (16 entries).
- `LOCK_MAX`, 4, maximum consecutive grants under `lock` before forced release.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_a` / `req_b`  in  1  operation request.
- `lock_a` / `lock_b`  in  1  request to keep the grant on the next cycle.
- `rd_a` / `rd_b`, `wr_a` / `wr_b`  in  1  operation type.
- `so1_a`, `so2_a`, `si_a` (and `_b`)  in  AW  read selects 1/2, write select.
- `wd_a` / `wd_b`  in  DW  write data.
- `gnt_a` / `gnt_b`  out  1  combinational grant; the operation issues this cycle.
- `rvalid_a` / `rvalid_b`  out  1  read data valid (registered strobe).
- `rdata1`, `rdata2`  out  DW  read data; meaningful only while an `rvalid_*` is high.
- `rf_en`, `rf_rd`, `rf_wr`  out  1  to register file `EN`/`RD`/`WR`.
- `rf_sel_o1`, `rf_sel_o2`, `rf_sel_i1`  out  AW  to register file selects.
- `rf_ip1`  out  DW  to register file write data.
- `rf_op1`, `rf_op2`  in  DW  from register file outputs.

## Operation
- At most one grant per cycle. Requester holds `req_*` and its operands stable until it sees `gnt_*`=1 in the same cycle.
- Round-robin pointer `prio` (0=A, 1=B), reset 0.
  - With both requests high, the `prio` side wins.
  - After a non-locked grant, `prio` moves to the other requester.
  - With a single request, that requester wins regardless of `prio`.
- FSM states: IDLE, OWN_A, OWN_B. Reset state is IDLE.
  - IDLE -> OWN_x on a grant to x with `lock_x`=1 and `req_x`=1.
  - While in OWN_x, x has absolute priority. `lock_cnt` increments on each grant.
  - OWN_x -> IDLE when `lock_x`=0, when `req_x`=0, or when `lock_cnt` reaches `LOCK_MAX-1` at a grant (forced release). On forced release `prio` moves to the other requester.
- Issue cycle: `rf_en`=1 and `rf_rd`/`rf_wr`/selects/`rf_ip1` are muxed from the granted requester. With no grant, `rf_en`=0 and the other `rf_*` outputs are 0.
- A granted request with `rd`=`wr`=0 is accepted as a no-op: `gnt` is high, `rf_en`=0, no response.
- Reads: the granted requester's `rvalid_*` pulses for 1 cycle in the following cycle, with `rdata1`/`rdata2` taken from `rf_op1`/`rf_op2`. Write-only operations produce no `rvalid`.
- Same-register read+write in one operation (`rd`=`wr`=1, `so1`==`si`): `rdata1` returns the pre-write value (default build). The same rule applies to `so2`.

## Timing
- Grant latency: 0 cycles (combinational from `req`, `prio`, FSM state).
- Read latency: issue in cycle T, `rvalid` and data in T+1. Back-to-back reads sustain 1 per cycle.
- Reset values: `rvalid_a`=`rvalid_b`=0, `prio`=0, `lock_cnt`=0, FSM=IDLE.
  - `gnt_*`=0 and `rf_en`=0 while `rst`=1.
  - `rdata*` is 0 after reset until the first read.
- Reset asserted mid-operation: a pending response is dropped (no `rvalid` in the next cycle) and any lock is released.
- A write in cycle T is visible to a read issued in T+1 or later.

## Configuration
- `RF_ARB_BYPASS_EN`
  - Defined: a 1-deep bypass register records the write select and data of each issued write. On a same-operation `rd`+`wr` collision, `rdata*` returns the new write data instead of the old value.
  - Undefined: no bypass logic; pre-write value is returned as specified above.

## Test plan
- Reset, then A writes 32'hDEAD_BEEF to r3; A reads `so1`=3, `so2`=0 -> `rvalid_a`=1 one cycle after grant, `rdata1`=32'hDEAD_BEEF, `rdata2`=0.
- A and B request simultaneously for 4 cycles, no lock -> grants alternate A,B,A,B. Each `rvalid` strobes only its requester.
- B holds `lock_b`=1 and `req_b`=1 for 6 cycles while A requests -> B granted 4 consecutive cycles, then A granted, then B.
- A issues `rd`=`wr`=1, `si`=`so1`=5, data 32'h1234_5678, with r5=0 -> `rdata1`=0 without the macro, 32'h1234_5678 with `RF_ARB_BYPASS_EN`.
- Read granted in cycle T, `rst`=1 in T+1 -> no `rvalid` in T+1; `gnt`=0 and `rf_en`=0 during reset; after release A wins first (`prio`=0).
- A request with `rd`=`wr`=0 -> `gnt_a`=1, `rf_en`=0, no `rvalid`, `prio` advances to B.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - two-requester round-robin register file port arbiter (optional RF_ARB_BYPASS_EN)
module rf_port_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 4,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          lock_a,
    input  logic          lock_b,
    input  logic          rd_a,
    input  logic          rd_b,
    input  logic          wr_a,
    input  logic          wr_b,
    input  logic [AW-1:0] so1_a,
    input  logic [AW-1:0] so2_a,
    input  logic [AW-1:0] si_a,
    input  logic [AW-1:0] so1_b,
    input  logic [AW-1:0] so2_b,
    input  logic [AW-1:0] si_b,
    input  logic [DW-1:0] wd_a,
    input  logic [DW-1:0] wd_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic          rf_en,
    output logic          rf_rd,
    output logic          rf_wr,
    output logic [AW-1:0] rf_sel_o1,
    output logic [AW-1:0] rf_sel_o2,
    output logic [AW-1:0] rf_sel_i1,
    output logic [DW-1:0] rf_ip1,
    input  logic [DW-1:0] rf_op1,
    input  logic [DW-1:0] rf_op2
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;
    localparam int         CW    = $clog2(LOCK_MAX) + 1;

    logic [1:0]    state;
    logic          prio;
    logic [CW-1:0] lock_cnt;
    logic          rv_a_q;
    logic          rv_b_q;
    logic [DW-1:0] rdata1_q;
    logic [DW-1:0] rdata2_q;

    logic          pick_a;
    logic          pick_b;
    logic          gnt_any;
    logic          g_owned;
    logic          issue;
    logic          g_rd;
    logic          g_wr;
    logic          g_lock;
    logic [AW-1:0] g_so1;
    logic [AW-1:0] g_so2;
    logic [AW-1:0] g_si;
    logic [DW-1:0] g_wd;

    // Arbitration: a lock owner that still requests wins, else round-robin, else the lone requester
    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (state == OWN_A && req_a) begin
            pick_a = 1'b1;
        end else if (state == OWN_B && req_b) begin
            pick_b = 1'b1;
        end else if (req_a && req_b) begin
            pick_a = ~prio;
            pick_b = prio;
        end else begin
            pick_a = req_a;
            pick_b = req_b;
        end
    end

    // No grant may escape while reset is held
    assign gnt_a   = pick_a & ~rst;
    assign gnt_b   = pick_b & ~rst;
    assign gnt_any = gnt_a | gnt_b;
    assign g_owned = (gnt_a && state == OWN_A) || (gnt_b && state == OWN_B);

    // Operand mux from the granted requester
    always_comb begin
        g_rd   = rd_a;
        g_wr   = wr_a;
        g_lock = lock_a;
        g_so1  = so1_a;
        g_so2  = so2_a;
        g_si   = si_a;
        g_wd   = wd_a;
        if (gnt_b) begin
            g_rd   = rd_b;
            g_wr   = wr_b;
            g_lock = lock_b;
            g_so1  = so1_b;
            g_so2  = so2_b;
            g_si   = si_b;
            g_wd   = wd_b;
        end
    end

    // A grant with neither rd nor wr is a no-op and leaves the file idle
    assign issue     = gnt_any & (g_rd | g_wr);
    assign rf_en     = issue;
    assign rf_rd     = issue & g_rd;
    assign rf_wr     = issue & g_wr;
    assign rf_sel_o1 = issue ? g_so1 : '0;
    assign rf_sel_o2 = issue ? g_so2 : '0;
    assign rf_sel_i1 = issue ? g_si  : '0;
    assign rf_ip1    = issue ? g_wd  : '0;

    // Lock ownership and round-robin pointer; lock_cnt counts grants within one lock run
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            lock_cnt <= '0;
        end else if (gnt_any) begin
            if (g_owned) begin
                if (!g_lock || lock_cnt == CW'(LOCK_MAX - 1)) begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                    prio     <= gnt_a;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end else if (g_lock && LOCK_MAX > 1) begin
                state    <= gnt_a ? OWN_A : OWN_B;
                lock_cnt <= CW'(1);
            end else begin
                state    <= IDLE;
                lock_cnt <= '0;
                prio     <= gnt_a;
            end
        end else begin
            state    <= IDLE;
            lock_cnt <= '0;
        end
    end

    // Read response: capture file outputs in the issue cycle, strobe the owner next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rv_a_q   <= 1'b0;
            rv_b_q   <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            rv_a_q <= gnt_a & g_rd;
            rv_b_q <= gnt_b & g_rd;
            if (issue && g_rd) begin
                rdata1_q <= rf_op1;
                rdata2_q <= rf_op2;
            end
        end
    end

    // A reset arriving in the response cycle drops the pending strobe
    assign rvalid_a = rv_a_q & ~rst;
    assign rvalid_b = rv_b_q & ~rst;

`ifdef RF_ARB_BYPASS_EN
    logic [DW-1:0] byp_data;
    logic          byp_hit1;
    logic          byp_hit2;

    // Bypass register: last write data, plus per-port collision flags for the last read
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_data <= '0;
            byp_hit1 <= 1'b0;
            byp_hit2 <= 1'b0;
        end else begin
            if (issue && g_wr) begin
                byp_data <= g_wd;
            end
            if (issue && g_rd) begin
                byp_hit1 <= g_wr && (g_so1 == g_si);
                byp_hit2 <= g_wr && (g_so2 == g_si);
            end
        end
    end

    assign rdata1 = byp_hit1 ? byp_data : rdata1_q;
    assign rdata2 = byp_hit2 ? byp_data : rdata2_q;
`else
    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;
`endif

endmodule
